serial_subtractor_beh: RTL and testbench

//  Bit-serial unsigned subtractor computing DIFF = A - B, LSB first, one bit per clock.

---
 rtl/sub_pkg.sv | 14 +
 rtl/full_subtractor_beh_case.sv | 27 ++
 rtl/serial_subtractor_beh.sv | 108 ++++++++++
 tb/tb_serial_subtractor_beh.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and width limits.
package sub_pkg;

   // Encoding 2'd3 is unused and is treated as IDLE by the FSM.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_RSVD = 2'd3
   } state_t;

   localparam int SUB_MIN_WIDTH = 2;

endpackage

// File: rtl/full_subtractor_beh_case.sv
// Behavioural one-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_beh_case (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Truth table written out, indexed by {a, b, bin}.
   always_comb begin
      d    = 1'b0;
      bout = 1'b0;
      case ({a, b, bin})
         3'b000: begin d = 1'b0; bout = 1'b0; end
         3'b001: begin d = 1'b1; bout = 1'b1; end
         3'b010: begin d = 1'b1; bout = 1'b1; end
         3'b011: begin d = 1'b0; bout = 1'b1; end
         3'b100: begin d = 1'b1; bout = 1'b0; end
         3'b101: begin d = 1'b0; bout = 1'b0; end
         3'b110: begin d = 1'b0; bout = 1'b0; end
         3'b111: begin d = 1'b1; bout = 1'b1; end
         default: begin d = 1'b0; bout = 1'b0; end
      endcase
   end

endmodule

// File: rtl/serial_subtractor_beh.sv
// Bit-serial unsigned subtractor (diff = a - b, LSB first) behind valid/ready handshakes.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor_beh
   import sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > SUB_MIN_WIDTH) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             d;
   logic             bout;

`ifdef SUB_OVERFLOW_EN
   logic             a_msb;
   logic             b_msb;
`endif

   full_subtractor_beh_case u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (d),
      .bout (bout)
   );

   // diff and borrow are the working registers themselves; they stay put in DONE and IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         borrow    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
`ifdef SUB_OVERFLOW_EN
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               diff   <= {d, diff[WIDTH-1:1]};
               borrow <= bout;
               if (cnt == CNT_LAST) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  borrow   <= 1'b0;
                  cnt      <= '0;
                  state    <= ST_RUN;
                  in_ready <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
`endif
               end
            end
         endcase
      end
   end

`ifdef SUB_OVERFLOW_EN
   assign ovf = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1]);
`endif

endmodule

// File: tb/tb_serial_subtractor_beh.sv
// Directed self-checking bench for serial_subtractor_beh (WIDTH=8); checks ovf when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_beh;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borrow;
`ifdef SUB_OVERFLOW_EN
   logic       ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

   serial_subtractor_beh #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
`ifdef SUB_OVERFLOW_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one operand pair for a single edge, then drop in_valid.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Count edges after the load edge until out_valid rises, bounded.
   task automatic waitDone(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!out_valid && cycles < 20);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 8'h00;
      b         = 8'h00;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_diff", diff, 8'h00);
      checkOutput("reset_borrow", borrow, 0);
`ifdef SUB_OVERFLOW_EN
      checkOutput("reset_ovf", ovf, 0);
`endif

      applyStimulus(8'h05, 8'h03);
      checkOutput("run_in_ready", in_ready, 0);
      waitDone(lat);
      checkOutput("lat_05_03", lat, 8);
      checkOutput("diff_05_03", diff, 8'h02);
      checkOutput("borrow_05_03", borrow, 0);
      tick();
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_diff_held", diff, 8'h02);

      applyStimulus(8'h03, 8'h05);
      waitDone(lat);
      checkOutput("diff_03_05", diff, 8'hFE);
      checkOutput("borrow_03_05", borrow, 1);
      tick();

      applyStimulus(8'h00, 8'hFF);
      waitDone(lat);
      checkOutput("diff_00_FF", diff, 8'h01);
      checkOutput("borrow_00_FF", borrow, 1);
      tick();

`ifdef SUB_OVERFLOW_EN
      applyStimulus(8'h80, 8'h01);
      waitDone(lat);
      checkOutput("diff_80_01", diff, 8'h7F);
      checkOutput("borrow_80_01", borrow, 0);
      checkOutput("ovf_80_01", ovf, 1);
      tick();

      applyStimulus(8'h10, 8'h01);
      waitDone(lat);
      checkOutput("diff_10_01", diff, 8'h0F);
      checkOutput("ovf_10_01", ovf, 0);
      tick();
`endif

      // Reset partway through a subtraction.
      applyStimulus(8'h33, 8'h11);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_in_ready", in_ready, 1);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_diff", diff, 8'h00);
      checkOutput("midrst_borrow", borrow, 0);

      applyStimulus(8'h0A, 8'h0A);
      waitDone(lat);
      checkOutput("lat_0A_0A", lat, 8);
      checkOutput("diff_0A_0A", diff, 8'h00);
      checkOutput("borrow_0A_0A", borrow, 0);
      tick();

      // Consumer stalls while a new pair is offered.
      out_ready = 1'b0;
      applyStimulus(8'h05, 8'h03);
      waitDone(lat);
      a        = 8'h77;
      b        = 8'h11;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold_out_valid", out_valid, 1);
         checkOutput("hold_in_ready", in_ready, 0);
         checkOutput("hold_diff", diff, 8'h02);
         checkOutput("hold_borrow", borrow, 0);
      end
      out_ready = 1'b1;
      tick();
      checkOutput("release_in_ready", in_ready, 1);
      checkOutput("release_out_valid", out_valid, 0);
      tick();
      in_valid = 1'b0;
      checkOutput("accept_in_ready", in_ready, 0);
      waitDone(lat);
      checkOutput("lat_77_11", lat, 8);
      checkOutput("diff_77_11", diff, 8'h66);
      checkOutput("borrow_77_11", borrow, 0);
      tick();

      // Back-to-back: in_valid stays high, second pair changes during RUN.
      a        = 8'h20;
      b        = 8'h01;
      in_valid = 1'b1;
      tick();
      a = 8'h01;
      b = 8'h02;
      waitDone(lat);
      checkOutput("b2b_lat1", lat, 8);
      checkOutput("b2b_diff1", diff, 8'h1F);
      checkOutput("b2b_borrow1", borrow, 0);
      tick();
      checkOutput("b2b_idle_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      checkOutput("b2b_load2", in_ready, 0);
      waitDone(lat);
      checkOutput("b2b_lat2", lat, 8);
      checkOutput("b2b_diff2", diff, 8'hFF);
      checkOutput("b2b_borrow2", borrow, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
